// File: rtl/instr_decode_stage_if.sv
// Fetch-to-decode handshake bundle: instruction/PC in, decoded fields out.
// The slave modport belongs to the decode stage, the master to whoever drives fetch and consumes results.
interface instr_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic                out_funct7_5;
  logic [19:0]         out_imm_field;
  logic                out_ext_op;
  logic                out_unsigned_op;
  logic [1:0]          out_imm_shift;
  logic                out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7_5, out_imm_field, out_ext_op, out_unsigned_op,
           out_imm_shift, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7_5, out_imm_field, out_ext_op, out_unsigned_op,
           out_imm_shift, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode stage with a 2-entry skid buffer feeding the immediate extender.
// The decoded result is registered in main (visible) or skid (overflow) so in_ready can be a flop.
module instr_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic [19:0]         imm_field;
    logic                ext_op;
    logic                unsigned_op;
    logic [1:0]          imm_shift;
    logic                illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic entry_t decode(input logic [31:0] i, input logic [PC_WIDTH-1:0] pc);
    entry_t e;
    e          = '0;
    e.pc       = pc;
    e.opcode   = i[6:0];
    e.rd       = i[11:7];
    e.rs1      = i[19:15];
    e.rs2      = i[24:20];
    e.funct3   = i[14:12];
    e.funct7_5 = i[30];
    case (i[6:0])
      7'b0110111, 7'b0010111: begin
        e.imm_field = i[31:12];
        e.ext_op    = 1'b1;
        e.imm_shift = 2'b10;
      end
      7'b1101111: begin
        e.imm_field = {i[31], i[19:12], i[20], i[30:21]};
        e.ext_op    = 1'b1;
        e.imm_shift = 2'b01;
      end
      7'b1100111, 7'b0000011, 7'b0010011: e.imm_field = {8'b0, i[31:20]};
      7'b0100011: e.imm_field = {8'b0, i[31:25], i[11:7]};
      7'b1100011: begin
        e.imm_field = {8'b0, i[31], i[7], i[30:25], i[11:8]};
        e.imm_shift = 2'b01;
      end
      7'b1110011: begin
        // Only the CSR-immediate forms carry a zimm; other SYSTEM ops have no immediate.
        if (i[14]) begin
          e.imm_field   = {15'b0, i[19:15]};
          e.unsigned_op = 1'b1;
        end
      end
      7'b0110011, 7'b0001111: ;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  state_t state, state_next;
  logic   ready_p1;
  logic   load_main, load_skid, move_skid;
  logic   in_xfer, out_xfer, vld_p1;
  entry_t dec_p0, main_p1, skid_p1;

  // ---- stage 0: combinational decode and buffer control ----
  assign dec_p0   = decode(bus.in_instr, bus.in_pc);
  assign vld_p1   = (state != EMPTY);
  assign in_xfer  = bus.in_valid & ready_p1;
  assign out_xfer = vld_p1 & bus.out_ready;

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            load_skid  = 1'b1;
            state_next = TWO;
          end else if (in_xfer && out_xfer) begin
            load_main  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          move_skid  = 1'b1;
          state_next = ONE;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      ready_p1 <= 1'b1;
    end else begin
      state    <= state_next;
      ready_p1 <= (state_next != TWO);
    end
  end

  // ---- stage 1: main/skid entry registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      main_p1 <= '0;
    end else if (load_main) begin
      main_p1 <= dec_p0;
    end else if (move_skid) begin
      main_p1 <= skid_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) skid_p1 <= dec_p0;
  end

  assign bus.in_ready        = ready_p1;
  assign bus.out_valid       = vld_p1;
  assign bus.out_pc          = main_p1.pc;
  assign bus.out_opcode      = main_p1.opcode;
  assign bus.out_rd          = main_p1.rd;
  assign bus.out_rs1         = main_p1.rs1;
  assign bus.out_rs2         = main_p1.rs2;
  assign bus.out_funct3      = main_p1.funct3;
  assign bus.out_funct7_5    = main_p1.funct7_5;
  assign bus.out_imm_field   = main_p1.imm_field;
  assign bus.out_ext_op      = main_p1.ext_op;
  assign bus.out_unsigned_op = main_p1.unsigned_op;
  assign bus.out_imm_shift   = main_p1.imm_shift;
  assign bus.out_illegal     = main_p1.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed-vector bench for instr_decode_stage: decode fields, skid buffering, flush and reset.
module tb_instr_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  instr_decode_stage_if #(.PC_WIDTH(32)) bus ();

  instr_decode_stage #(.PC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction into an empty stage and hold it on the outputs.
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
    checks++; if (bus.out_imm_field !== 20'h0) begin errors++; $display("FAIL reset_field got %h want 0", bus.out_imm_field); end
  endtask

  task automatic test_addi();
    send_one(32'hFFF00093, 32'h100);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h100) begin errors++; $display("FAIL addi_pc got %h want 100", bus.out_pc); end
    checks++; if (bus.out_opcode !== 7'h13) begin errors++; $display("FAIL addi_opcode got %h want 13", bus.out_opcode); end
    checks++; if (bus.out_rd !== 5'd1 || bus.out_rs1 !== 5'd0) begin errors++; $display("FAIL addi_regs got rd=%0d rs1=%0d want rd=1 rs1=0", bus.out_rd, bus.out_rs1); end
    checks++; if (bus.out_imm_field !== 20'h00FFF) begin errors++; $display("FAIL addi_field got %h want 00fff", bus.out_imm_field); end
    checks++; if ({bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift, bus.out_illegal} !== 5'b00000) begin errors++; $display("FAIL addi_ctrl got %b want 00000", {bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift, bus.out_illegal}); end
    drain();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL addi_consumed got %b want 0", bus.out_valid); end
  endtask

  task automatic test_upper_jump();
    send_one(32'h123452B7, 32'h110);
    checks++; if (bus.out_imm_field !== 20'h12345) begin errors++; $display("FAIL lui_field got %h want 12345", bus.out_imm_field); end
    checks++; if ({bus.out_ext_op, bus.out_imm_shift} !== 3'b110 || bus.out_rd !== 5'd5) begin errors++; $display("FAIL lui_ctrl got ext/shift=%b rd=%0d want 110 rd=5", {bus.out_ext_op, bus.out_imm_shift}, bus.out_rd); end
    drain();
    send_one(32'hFFDFF0EF, 32'h114);
    checks++; if (bus.out_imm_field !== 20'hFFFFE) begin errors++; $display("FAIL jal_field got %h want ffffe", bus.out_imm_field); end
    checks++; if ({bus.out_ext_op, bus.out_imm_shift} !== 3'b101 || bus.out_rd !== 5'd1) begin errors++; $display("FAIL jal_ctrl got ext/shift=%b rd=%0d want 101 rd=1", {bus.out_ext_op, bus.out_imm_shift}, bus.out_rd); end
    drain();
  endtask

  task automatic test_branch_store();
    send_one(32'hFE000EE3, 32'h118);
    checks++; if (bus.out_imm_field !== 20'h00FFE) begin errors++; $display("FAIL beq_field got %h want 00ffe", bus.out_imm_field); end
    checks++; if ({bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift} !== 4'b0001) begin errors++; $display("FAIL beq_ctrl got %b want 0001", {bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift}); end
    drain();
    send_one(32'h0020A423, 32'h11C);
    checks++; if (bus.out_imm_field !== 20'h00008) begin errors++; $display("FAIL sw_field got %h want 00008", bus.out_imm_field); end
    checks++; if (bus.out_rs2 !== 5'd2 || bus.out_funct3 !== 3'd2 || bus.out_imm_shift !== 2'b00) begin errors++; $display("FAIL sw_fields got rs2=%0d f3=%0d shift=%b want 2 2 00", bus.out_rs2, bus.out_funct3, bus.out_imm_shift); end
    drain();
  endtask

  task automatic test_csr_illegal();
    send_one(32'h0050E073, 32'h120);
    checks++; if (bus.out_imm_field !== 20'h00001) begin errors++; $display("FAIL csri_field got %h want 00001", bus.out_imm_field); end
    checks++; if ({bus.out_ext_op, bus.out_unsigned_op, bus.out_illegal} !== 3'b010 || bus.out_funct3 !== 3'd6) begin errors++; $display("FAIL csri_ctrl got %b f3=%0d want 010 f3=6", {bus.out_ext_op, bus.out_unsigned_op, bus.out_illegal}, bus.out_funct3); end
    drain();
    send_one(32'h00000000, 32'h124);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_imm_field !== 20'h0) begin errors++; $display("FAIL zero_illegal got ill=%b field=%h want 1 00000", bus.out_illegal, bus.out_imm_field); end
    drain();
    send_one(32'hFFFFFFFF, 32'h128);
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_imm_field !== 20'h0 || {bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift} !== 4'b0000) begin errors++; $display("FAIL ones_illegal got ill=%b field=%h ctrl=%b want 1 00000 0000", bus.out_illegal, bus.out_imm_field, {bus.out_ext_op, bus.out_unsigned_op, bus.out_imm_shift}); end
    checks++; if (bus.out_rd !== 5'd31 || bus.out_rs1 !== 5'd31 || bus.out_funct7_5 !== 1'b1) begin errors++; $display("FAIL ones_passthru got rd=%0d rs1=%0d f7=%b want 31 31 1", bus.out_rd, bus.out_rs1, bus.out_funct7_5); end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00100093;
    bus.in_pc     = 32'h200;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_pc !== 32'h200) begin errors++; $display("FAIL bp_a got rdy=%b pc=%h want 1 200", bus.in_ready, bus.out_pc); end
    bus.in_pc = 32'h204;
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h200) begin errors++; $display("FAIL bp_b got rdy=%b pc=%h want 0 200", bus.in_ready, bus.out_pc); end
    bus.in_pc = 32'h208;
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_pc !== 32'h200 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%b pc=%h vld=%b want 0 200 1", bus.in_ready, bus.out_pc, bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_pc !== 32'h204) begin errors++; $display("FAIL bp_out_b got rdy=%b pc=%h want 1 204", bus.in_ready, bus.out_pc); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h208) begin errors++; $display("FAIL bp_out_c got vld=%b pc=%h want 1 208", bus.out_valid, bus.out_pc); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00200113;
    bus.in_pc     = 32'h300;
    tick();
    bus.in_pc = 32'h304;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fl_two got rdy=%b want 0", bus.in_ready); end
    bus.flush = 1'b1;
    bus.in_pc = 32'h308;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_two_after got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    send_one(32'h00300193, 32'h30C);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h30C || bus.out_rd !== 5'd3) begin errors++; $display("FAIL fl_next got vld=%b pc=%h rd=%0d want 1 30c 3", bus.out_valid, bus.out_pc, bus.out_rd); end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h310;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL fl_one_drop got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h123452B7;
    bus.in_pc     = 32'h400;
    tick();
    bus.in_pc = 32'h404;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_imm_field !== 20'h12345) begin errors++; $display("FAIL rs_full got rdy=%b field=%h want 0 12345", bus.in_ready, bus.out_imm_field); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rs_ctrl got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.out_pc !== 32'h0 || bus.out_imm_field !== 20'h0 || bus.out_rd !== 5'd0 || bus.out_opcode !== 7'h0 || bus.out_ext_op !== 1'b0 || bus.out_imm_shift !== 2'b00) begin errors++; $display("FAIL rs_data got pc=%h field=%h rd=%0d op=%h want all 0", bus.out_pc, bus.out_imm_field, bus.out_rd, bus.out_opcode); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h00500293;
    bus.in_pc     = 32'h500;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500) begin errors++; $display("FAIL rs_resume1 got vld=%b pc=%h want 1 500", bus.out_valid, bus.out_pc); end
    bus.in_pc = 32'h504;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h504 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rs_resume2 got vld=%b pc=%h rdy=%b want 1 504 1", bus.out_valid, bus.out_pc, bus.in_ready); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rs_drain got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_upper_jump();
    test_branch_store();
    test_csr_illegal();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
